// File: rtl/raster_scheduler_if.sv
// raster_scheduler_if
// Bundles the tracer-facing pixel request/response signals and the
// display-facing valid/ready pixel stream of the raster scheduler.
// master: the scheduler. slave: the tracer plus display side seen from outside.
interface raster_scheduler_if;
    // Request to the tracer
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       pixel_valid;
    // Response from the tracer
    logic       trace_done;
    logic [7:0] rgb_r;
    logic [7:0] rgb_g;
    logic [7:0] rgb_b;
    // Output pixel stream
    logic       out_valid;
    logic       out_ready;
    logic [5:0] out_rgb;
    logic [9:0] out_x;
    logic [9:0] out_y;
    logic       out_last;

    modport master (
        output pixel_x, pixel_y, pixel_valid,
        input  trace_done, rgb_r, rgb_g, rgb_b,
        output out_valid, out_rgb, out_x, out_y, out_last,
        input  out_ready
    );

    modport slave (
        input  pixel_x, pixel_y, pixel_valid,
        output trace_done, rgb_r, rgb_g, rgb_b,
        input  out_valid, out_rgb, out_x, out_y, out_last,
        output out_ready
    );
endinterface

// File: rtl/raster_scheduler.sv
// raster_scheduler
// Walks an H_RES x V_RES raster, issues one start strobe per pixel to the
// ray-tracing core, waits for its colour (or substitutes magenta after a
// per-pixel watchdog expires), quantises the colour to RGB222 and hands it
// to the display side over a valid/ready handshake.
// Optional feature: define RASTER_DITHER_EN to apply a 2x2 ordered dither
// ahead of quantisation; when undefined the colour is simply truncated.
module raster_scheduler #(
    parameter int H_RES   = 320,
    parameter int V_RES   = 240,
    parameter int TIMEOUT = 63
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      frame_start_i,
    raster_scheduler_if.master        bus,
    output logic                      frame_busy_o,
    output logic                      frame_done_o,
    output logic [7:0]                timeout_count_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_EMIT  = 2'd3
    } state_t;

    localparam logic [9:0] X_LAST    = 10'(H_RES - 1);
    localparam logic [9:0] Y_LAST    = 10'(V_RES - 1);
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    // Fallback colour used when the tracer never answers
    localparam logic [7:0] FB_R = 8'd255;
    localparam logic [7:0] FB_G = 8'd0;
    localparam logic [7:0] FB_B = 8'd255;

`ifdef RASTER_DITHER_EN
    // 2x2 ordered-dither threshold selected by the pixel's position parity
    function automatic logic [7:0] dither_offset(input logic y_lsb, input logic x_lsb);
        logic [7:0] off;
        case ({y_lsb, x_lsb})
            2'b00:   off = 8'd0;
            2'b01:   off = 8'd32;
            2'b10:   off = 8'd48;
            2'b11:   off = 8'd16;
            default: off = 8'd0;
        endcase
        return off;
    endfunction

    // Saturating add of the dither offset, then keep the two MSBs
    function automatic logic [1:0] quantise(input logic [7:0] c, input logic [7:0] off);
        logic [8:0] sum;
        sum = {1'b0, c} + {1'b0, off};
        if (sum[8]) begin
            return 2'b11;
        end else begin
            return 2'(sum[7:0] >> 3'd6);
        end
    endfunction
`else
    // Plain truncation to the two MSBs
    function automatic logic [1:0] quantise(input logic [7:0] c);
        return 2'(c >> 3'd6);
    endfunction
`endif

    state_t     state_q;
    logic [9:0] x_q;
    logic [9:0] y_q;
    logic [7:0] wait_cnt_q;
    logic       pixel_valid_q;
    logic       out_valid_q;
    logic [5:0] out_rgb_q;
    logic [9:0] out_x_q;
    logic [9:0] out_y_q;
    logic       out_last_q;
    logic       frame_busy_q;
    logic       frame_done_q;
    logic [7:0] timeout_count_q;

    logic [7:0] src_r_s;
    logic [7:0] src_g_s;
    logic [7:0] src_b_s;
    logic [5:0] out_rgb_d;

    // Select tracer colour or fallback and quantise it for the current pixel
    always_comb begin
        src_r_s = FB_R;
        src_g_s = FB_G;
        src_b_s = FB_B;
        if (bus.trace_done) begin
            src_r_s = bus.rgb_r;
            src_g_s = bus.rgb_g;
            src_b_s = bus.rgb_b;
        end else begin
            src_r_s = FB_R;
            src_g_s = FB_G;
            src_b_s = FB_B;
        end
`ifdef RASTER_DITHER_EN
        out_rgb_d = {quantise(src_r_s, dither_offset(y_q[0], x_q[0])),
                     quantise(src_g_s, dither_offset(y_q[0], x_q[0])),
                     quantise(src_b_s, dither_offset(y_q[0], x_q[0]))};
`else
        out_rgb_d = {quantise(src_r_s), quantise(src_g_s), quantise(src_b_s)};
`endif
    end

    // Frame sequencer: raster walk, tracer handshake, watchdog and output stream
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            x_q             <= 10'd0;
            y_q             <= 10'd0;
            wait_cnt_q      <= 8'd0;
            pixel_valid_q   <= 1'b0;
            out_valid_q     <= 1'b0;
            out_rgb_q       <= 6'd0;
            out_x_q         <= 10'd0;
            out_y_q         <= 10'd0;
            out_last_q      <= 1'b0;
            frame_busy_q    <= 1'b0;
            frame_done_q    <= 1'b0;
            timeout_count_q <= 8'd0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (frame_start_i) begin
                        x_q             <= 10'd0;
                        y_q             <= 10'd0;
                        timeout_count_q <= 8'd0;
                        pixel_valid_q   <= 1'b1;
                        frame_busy_q    <= 1'b1;
                        state_q         <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    pixel_valid_q <= 1'b0;
                    wait_cnt_q    <= 8'd0;
                    state_q       <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.trace_done || (wait_cnt_q == WAIT_LAST)) begin
                        out_rgb_q   <= out_rgb_d;
                        out_x_q     <= x_q;
                        out_y_q     <= y_q;
                        out_last_q  <= (x_q == X_LAST) && (y_q == Y_LAST);
                        out_valid_q <= 1'b1;
                        state_q     <= ST_EMIT;
                        // A late answer on the watchdog cycle still counts as an answer
                        if (!bus.trace_done && (timeout_count_q != 8'd255)) begin
                            timeout_count_q <= timeout_count_q + 8'd1;
                        end
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                    end
                end
                ST_EMIT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        if ((x_q == X_LAST) && (y_q == Y_LAST)) begin
                            frame_done_q <= 1'b1;
                            frame_busy_q <= 1'b0;
                            state_q      <= ST_IDLE;
                        end else begin
                            if (x_q == X_LAST) begin
                                x_q <= 10'd0;
                                y_q <= y_q + 10'd1;
                            end else begin
                                x_q <= x_q + 10'd1;
                            end
                            pixel_valid_q <= 1'b1;
                            state_q       <= ST_ISSUE;
                        end
                    end
                end
                default: begin
                    pixel_valid_q <= 1'b0;
                    out_valid_q   <= 1'b0;
                    frame_busy_q  <= 1'b0;
                    state_q       <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.pixel_x      = x_q;
    assign bus.pixel_y      = y_q;
    assign bus.pixel_valid  = pixel_valid_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_rgb      = out_rgb_q;
    assign bus.out_x        = out_x_q;
    assign bus.out_y        = out_y_q;
    assign bus.out_last     = out_last_q;
    assign frame_busy_o     = frame_busy_q;
    assign frame_done_o     = frame_done_q;
    assign timeout_count_o  = timeout_count_q;

endmodule

// File: tb/tb_raster_scheduler.sv
// tb_raster_scheduler
// Directed bench for raster_scheduler on a 4x2 raster with TIMEOUT=5.
// Expected output beats are pushed to a scoreboard queue when the tracer
// response (or its absence) is driven and popped when out_valid appears.
module tb_raster_scheduler;

    localparam int H  = 4;
    localparam int V  = 2;
    localparam int TO = 5;

`ifdef RASTER_DITHER_EN
    localparam bit DITHER = 1'b1;
`else
    localparam bit DITHER = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_start = 1'b0;
    logic       frame_busy;
    logic       frame_done;
    logic [7:0] timeout_count;

    raster_scheduler_if bus ();

    raster_scheduler #(.H_RES(H), .V_RES(V), .TIMEOUT(TO)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .frame_start_i   (frame_start),
        .bus             (bus),
        .frame_busy_o    (frame_busy),
        .frame_done_o    (frame_done),
        .timeout_count_o (timeout_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0] rgb;
        logic [9:0] x;
        logic [9:0] y;
        logic       last;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   ex_x  = 0;
    int   ex_y  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] q2(input int c, input int off);
        int v;
        v = c + off;
        if (v > 255) v = 255;
        return 2'(v / 64);
    endfunction

    function automatic logic [5:0] model_rgb(input int r, input int g, input int b,
                                             input int x, input int y);
        int off;
        if      ((y % 2 == 0) && (x % 2 == 1)) off = 32;
        else if ((y % 2 == 1) && (x % 2 == 0)) off = 48;
        else if ((y % 2 == 1) && (x % 2 == 1)) off = 16;
        else                                   off = 0;
        if (!DITHER) off = 0;
        return {q2(r, off), q2(g, off), q2(b, off)};
    endfunction

    task automatic start_frame();
        frame_start = 1'b1;
        cycle();
        frame_start = 1'b0;
        chk("start_busy_pv", {62'd0, frame_busy, bus.pixel_valid}, 64'd3);
        ex_x = 0;
        ex_y = 0;
    endtask

    // k = 0: tracer silent (watchdog); k >= 1: trace_done k cycles after pixel_valid
    task automatic do_pixel(input int k, input logic [7:0] r, input logic [7:0] g,
                            input logic [7:0] b, input int hold);
        exp_t e;
        exp_t got;
        bit   found;
        bit   last;
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.pixel_valid === 1'b1) begin
                found = 1'b1;
                break;
            end
            cycle();
        end
        chk("pixel_valid_seen", {63'd0, found}, 64'd1);
        if (!found) return;
        chk("pixel_xy", {44'd0, bus.pixel_x, bus.pixel_y}, {44'd0, 10'(ex_x), 10'(ex_y)});
        last = (ex_x == H - 1) && (ex_y == V - 1);
        e.x = 10'(ex_x);
        e.y = 10'(ex_y);
        e.last = last;
        cycle();
        chk("pixel_valid_pulse", {63'd0, bus.pixel_valid}, 64'd0);
        if (k == 0) begin
            frame_start = 1'b1;
            cycle();
            frame_start = 1'b0;
            repeat (TO - 2) cycle();
            chk("timeout_early", {63'd0, bus.out_valid}, 64'd0);
            e.rgb = model_rgb(255, 0, 255, ex_x, ex_y);
            sb.push_back(e);
            cycle();
        end else begin
            repeat (k - 1) cycle();
            chk("done_early", {63'd0, bus.out_valid}, 64'd0);
            bus.trace_done = 1'b1;
            bus.rgb_r = r;
            bus.rgb_g = g;
            bus.rgb_b = b;
            e.rgb = model_rgb(int'(r), int'(g), int'(b), ex_x, ex_y);
            sb.push_back(e);
            cycle();
            bus.trace_done = 1'b0;
            bus.rgb_r = 8'h00;
            bus.rgb_g = 8'h00;
            bus.rgb_b = 8'h00;
        end
        chk("out_valid_latency", {63'd0, bus.out_valid}, 64'd1);
        got = sb.pop_front();
        chk("out_beat", {37'd0, bus.out_rgb, bus.out_x, bus.out_y, bus.out_last}, {37'd0, got});
        for (int i = 0; i < hold; i++) begin
            if (i == 0) begin
                bus.trace_done = 1'b1;
                bus.rgb_r = 8'h00;
                bus.rgb_g = 8'h00;
                bus.rgb_b = 8'h00;
            end
            cycle();
            bus.trace_done = 1'b0;
            chk("hold_stable", {36'd0, bus.out_valid, bus.out_rgb, bus.out_x, bus.out_y, bus.out_last},
                {36'd0, 1'b1, got});
            chk("hold_no_issue", {63'd0, bus.pixel_valid}, 64'd0);
        end
        bus.out_ready = 1'b1;
        cycle();
        bus.out_ready = 1'b0;
        chk("out_valid_drop", {63'd0, bus.out_valid}, 64'd0);
        if (last) begin
            chk("frame_done_pulse", {62'd0, frame_done, frame_busy}, 64'd2);
        end else begin
            chk("next_issue", {62'd0, bus.pixel_valid, frame_done}, 64'd2);
            if (ex_x == H - 1) begin
                ex_x = 0;
                ex_y = ex_y + 1;
            end else begin
                ex_x = ex_x + 1;
            end
        end
    endtask

    function automatic logic [63:0] all_outputs();
        return {5'd0, bus.pixel_valid, bus.out_valid, bus.out_last, frame_busy, frame_done,
                timeout_count, bus.pixel_x, bus.pixel_y, bus.out_rgb, bus.out_x, bus.out_y};
    endfunction

    initial begin
        bus.trace_done = 1'b0;
        bus.rgb_r = 8'h00;
        bus.rgb_g = 8'h00;
        bus.rgb_b = 8'h00;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (2) cycle();
        chk("reset_outputs", all_outputs(), 64'd0);
        rst_n = 1'b1;
        cycle();
        chk("idle_not_busy", {63'd0, frame_busy}, 64'd0);

        // Frame 1: tracer answers 2 cycles after each strobe
        start_frame();
        for (int i = 0; i < H * V; i++) begin
            if (i < 2) do_pixel(2, 8'hB0, 8'hB0, 8'hB0, 0);
            else       do_pixel(2, 8'(i * 53 + 17), 8'(i * 97 + 3), 8'(255 - i * 29), 0);
        end
        cycle();
        chk("frame_done_one_cycle", {63'd0, frame_done}, 64'd0);
        chk("f1_timeout_count", {56'd0, timeout_count}, 64'd0);

        // Frame 2: tracer silent, every pixel hits the watchdog
        start_frame();
        for (int i = 0; i < H * V; i++) do_pixel(0, 8'h00, 8'h00, 8'h00, 0);
        chk("f2_timeout_count", {56'd0, timeout_count}, 64'd8);
        repeat (5) cycle();
        chk("f2_count_holds", {56'd0, timeout_count}, 64'd8);

        // Frame 3: back-pressure, coincident answer, mixed timing
        start_frame();
        chk("f3_count_cleared", {56'd0, timeout_count}, 64'd0);
        do_pixel(1, 8'h12, 8'h9A, 8'hE7, 10);
        do_pixel(TO, 8'h40, 8'h80, 8'hC0, 0);
        chk("coincident_no_count", {56'd0, timeout_count}, 64'd0);
        do_pixel(0, 8'h00, 8'h00, 8'h00, 0);
        chk("one_timeout_count", {56'd0, timeout_count}, 64'd1);
        for (int i = 3; i < H * V; i++) do_pixel(1, 8'(i * 31), 8'(i * 71 + 9), 8'(i * 13 + 200), 0);

        // Frame 4 starts on the frame_done cycle, then reset mid-WAIT
        start_frame();
        cycle();
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", all_outputs(), 64'd0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("reset_no_done", {62'd0, frame_done, frame_busy}, 64'd0);
        end
        rst_n = 1'b1;
        cycle();
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        // Frame 5: fresh start after reset restarts at (0,0)
        start_frame();
        for (int i = 0; i < H * V; i++) do_pixel(3, 8'(i * 29 + 7), 8'(i * 41), 8'(250 - i * 17), 0);
        cycle();
        chk("f5_idle", {62'd0, frame_busy, frame_done}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
